shift_issue: RTL and testbench

Command buffer and result register placed directly upstream of the combinational 32-bit barrel shifter `shift`. Accepts shift commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Drives the head command onto the shifter's inputs, then captures the shifter's output into a registered result stage with its own valid/ready handshake. This gives the datapath a clean, back-pressurable, one-command-per-cycle shift unit.

---
 rtl/shift_issue.sv | 147 ++++++++++++++
 tb/tb_shift_issue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// shift_issue: DEPTH-entry command FIFO feeding the combinational barrel shifter `shift`,
// plus a registered result stage. Define SHIFT_ISSUE_BYPASS_EN for the empty-FIFO bypass path.

module shift (
  input  logic [31:0] data,
  input  logic [4:0]  s,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] result
);
  logic [31:0] w_in_rev;
  logic [31:0] w_out_rev;
  logic [31:0] w_stage [0:5];
  logic        w_fill;

  assign w_fill = right & arith & data[31];

  // Left shifts reuse the right-shift ladder on bit-reversed data.
  for (genvar gi = 0; gi < 32; gi++) begin : g_rev
    assign w_in_rev[gi]  = data[31-gi];
    assign w_out_rev[gi] = w_stage[5][31-gi];
  end

  assign w_stage[0] = right ? data : w_in_rev;

  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign w_stage[gi+1] = s[gi] ? {{SH{w_fill}}, w_stage[gi][31:SH]} : w_stage[gi];
  end

  assign result = right ? w_stage[5] : w_out_rev;
endmodule

module shift_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [4:0]               in_s,
  input  logic                     in_right,
  input  logic                     in_arith,
  output logic [31:0]              sh_data,
  output logic [4:0]               sh_s,
  output logic                     sh_right,
  output logic                     sh_arith,
  input  logic [31:0]              sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + 5 + 1 + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [31:0]   r_out_result;

  logic [EW-1:0] w_head;
  logic [EW-1:0] w_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_free;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_fire;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_free   = !r_out_valid || out_ready;
  assign in_ready = rst_n && !w_full;

`ifdef SHIFT_ISSUE_BYPASS_EN
  // An empty FIFO plus a free result stage lets the command skip storage entirely.
  assign w_bypass = rst_n && w_empty && in_valid && w_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push  = in_valid && in_ready && !w_bypass;
  assign w_pop   = !w_empty && w_free;
  assign w_fire  = w_pop || w_bypass;
  assign w_entry = {in_data, in_s, in_right, in_arith};
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    sh_data  = '0;
    sh_s     = '0;
    sh_right = 1'b0;
    sh_arith = 1'b0;
    if (w_bypass) begin
      sh_data  = in_data;
      sh_s     = in_s;
      sh_right = in_right;
      sh_arith = in_arith;
    end else if (!w_empty) begin
      {sh_data, sh_s, sh_right, sh_arith} = w_head;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_fire) begin
        r_out_valid  <= 1'b1;
        r_out_result <= sh_result;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign count      = r_count;
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with the real `shift` module in the loop.
// Covers single commands, back-pressure, full-with-pop, streaming and async reset.

module tb_shift_issue;
  localparam int DEPTH = 4;
`ifdef SHIFT_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_s;
  logic        in_right, in_arith;
  logic [31:0] sh_data;
  logic [4:0]  sh_s;
  logic        sh_right, sh_arith;
  logic [31:0] sh_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_s(in_s),
    .in_right(in_right), .in_arith(in_arith),
    .sh_data(sh_data), .sh_s(sh_s), .sh_right(sh_right), .sh_arith(sh_arith),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .count(count)
  );

  shift u_shift (
    .data(sh_data), .s(sh_s), .right(sh_right), .arith(sh_arith), .result(sh_result)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  s;
    logic        right;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t        vecs [7];
    logic [31:0] exp_q [$];
    logic [31:0] all1;
    int          lat, got, gaps, maxc, acc;

    vecs[0] = '{32'hff0000ff, 5'd8,  1'b0, 1'b0, 32'h0000ff00};
    vecs[1] = '{32'hff0000ff, 5'd8,  1'b1, 1'b0, 32'h00ff0000};
    vecs[2] = '{32'hff0000ff, 5'd8,  1'b1, 1'b1, 32'hffff0000};
    vecs[3] = '{32'hff0000ff, 5'd0,  1'b1, 1'b1, 32'hff0000ff};
    vecs[4] = '{32'h80000000, 5'd31, 1'b1, 1'b1, 32'hffffffff};
    vecs[5] = '{32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001};
    vecs[6] = '{32'h00000003, 5'd31, 1'b0, 1'b1, 32'h80000000};
    all1 = '1;

    // Reset state, with a command offered so bypass gating is exercised too.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h12345678; in_s = 5'd4;
    in_right = 1'b1; in_arith = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_sh_data", sh_data, 32'd0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Single commands: latency and result.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = vecs[i].data; in_s = vecs[i].s;
      in_right = vecs[i].right; in_arith = vecs[i].arith;
      in_valid = 1'b1;
      check("single_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("single_sh_data", sh_data, (LAT == 2) ? vecs[i].data : 32'd0);
      lat = 1;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      check("single_latency", 32'(lat), 32'(LAT));
      check("single_result", out_result, vecs[i].exp);
      $display("single %0d: data=%h s=%0d right=%0d arith=%0d -> %h (latency %0d)",
               i, vecs[i].data, vecs[i].s, vecs[i].right, vecs[i].arith, out_result, lat);
      tick();
      check("single_drained", 32'(out_valid), 32'd0);
    end

    // Streaming: 16 arithmetic right shifts of 0x80000001 by 0..15.
    in_data = 32'h80000001; in_right = 1'b1; in_arith = 1'b1;
    got = 0; gaps = 0; maxc = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 16) begin
        in_s = 5'(k);
        in_valid = 1'b1;
        check("stream_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back((k == 0) ? 32'h80000001 : ~(all1 >> (k + 1)));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (int'(count) > maxc) maxc = int'(count);
      if (out_valid) begin
        got++;
        if (exp_q.size() > 0) check("stream_result", out_result, exp_q.pop_front());
        else check("stream_extra", 32'(got), 32'd16);
        $display("stream result %0d: %h", got, out_result);
      end else if (got > 0 && got < 16) begin
        gaps++;
      end
    end
    check("stream_count", 32'(got), 32'd16);
    check("stream_gaps", 32'(gaps), 32'd0);
    check("stream_max_count", 32'(maxc), (LAT == 2) ? 32'd1 : 32'd0);

    // Back-pressure: 6 offered, 5 accepted, first result held stable.
    out_ready = 1'b0; in_right = 1'b0; in_arith = 1'b0; in_data = 32'h00000011;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_s = 5'(4 * i);
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
      if (out_valid) check("bp_stable", out_result, 32'h00000011);
      $display("bp push %0d: count=%0d in_ready=%0d", i, count, in_ready);
    end
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);

    // Full FIFO with a pop on the same edge: the offered sixth command is refused.
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    check("bp_result1", out_result, 32'h00000110);
    tick(); check("bp_result2", out_result, 32'h00001100);
    tick(); check("bp_result3", out_result, 32'h00011000);
    tick(); check("bp_result4", out_result, 32'h00110000);
    check("bp_valid4", 32'(out_valid), 32'd1);
    tick();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Async reset mid-operation with count=3 and a held result.
    out_ready = 1'b0; in_data = 32'h0000000f; in_s = 5'd1; in_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_sh_data", sh_data, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1; in_data = 32'h00000005; in_s = 5'd2; in_right = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("post_rst_latency", 32'(lat), 32'(LAT));
    check("post_rst_result", out_result, 32'h00000014);
    $display("post-reset command -> %h (latency %0d)", out_result, lat);
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
